// File: rtl/lsu_mem_master.sv
// Load/store unit front end for a single-port word memory with a combinational read.
// Sub-word stores are done as read-modify-write; bad requests answer with resp_err and never touch memory.
module lsu_mem_master #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        writeEn,
  input  logic [31:0] RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic [4:0]  lane_sh;
  logic [31:0] rd_sh;
  logic [31:0] ld_ext;
  logic [31:0] lane_mask;
  logic [31:0] wd_merge;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if ({1'b0, req_addr} >= MEM_BYTES) req_err = 1'b1;
  end

  // Little-endian lane select: shifting by the byte offset brings the addressed lane to bit 0.
  always_comb begin
    lane_sh = {addr_q[1:0], 3'b000};
    rd_sh   = RD >> lane_sh;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, rd_sh[7:0]}  : {{24{rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   ld_ext = uns_q ? {16'd0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: ld_ext = RD;
    endcase
    case (size_q)
      2'b00:   lane_mask = 32'h0000_00FF << lane_sh;
      2'b01:   lane_mask = 32'h0000_FFFF << lane_sh;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
    wd_merge = (word_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = req_err;
          if (req_err)                          state_d = RESP;
          else if (!req_we || req_size != 2'b10) state_d = READ;
          else                                  state_d = WRITE;
        end
      end
      READ: begin
        word_d = RD;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = ld_ext;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // All strobes decode straight from state, so an async reset drops writeEn without a clock edge.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign writeEn    = (state_q == WRITE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign A          = {2'b00, addr_q[31:2]};
  assign WD         = writeEn ? ((size_q == 2'b10) ? wdata_q : wd_merge) : 32'd0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural word memory and a response scoreboard.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, A, WD, RD;
  logic        writeEn;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [31:0] mem [256];
  bit          mem_init;
  int          wr_count = 0;
  logic [31:0] last_wd, last_a;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = 8'd0;
  logic [31:0] pre_dat = 32'd0;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_WORDS(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .A(A), .WD(WD),
    .writeEn(writeEn), .RD(RD)
  );

  assign RD = mem[A[7:0]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem_init <= 1'b1;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_dat;
    end else if (writeEn) begin
      mem[A[7:0]] <= WD;
      wr_count    <= wr_count + 1;
      last_wd     <= WD;
      last_a      <= A;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [7:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_dat = dat;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
    int n;
    exp_t e;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    e.err = exp_err; e.rdata = exp_rdata;
    sb.push_back(e);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string tag);
    int n;
    exp_t e;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      if (!resp_valid) begin
        chk({tag, "_resp_timeout"}, 32'(resp_valid), 32'd1);
      end else begin
        chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int          wc0;
    logic [31:0] snap_rdata;
    logic        snap_err;
    int          n;
    exp_t        e;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_writeEn", 32'(writeEn), 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_WD", WD, 32'd0);
    chk("rst_rdata_err", {resp_rdata[30:0], resp_err}, 32'd0);
    rst = 1'b1;

    // Word store then word load
    wc0 = wr_count;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0);
    wait_resp("wst");
    chk("wst_pulses", 32'(wr_count - wc0), 32'd1);
    chk("wst_A", last_a, 32'd4);
    chk("wst_WD", last_wd, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF);
    wait_resp("wld");

    // Byte read-modify-write and sub-word loads
    preset(8'd4, 32'h11223344);
    wc0 = wr_count;
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h123456AA, 1'b0, 32'd0);
    wait_resp("bst");
    chk("bst_pulses", 32'(wr_count - wc0), 32'd1);
    chk("bst_WD", last_wd, 32'h11AA3344);
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'd0, 1'b0, 32'hFFFFFFAA);
    wait_resp("lb_s");
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'd0, 1'b0, 32'h000000AA);
    wait_resp("lb_u");
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0, 32'h00000011);
    wait_resp("lb_s3");

    preset(8'd5, 32'h55667788);
    do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'h0000BEEF, 1'b0, 32'd0);
    wait_resp("hst");
    chk("hst_WD", last_wd, 32'hBEEF7788);
    do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'd0, 1'b0, 32'hFFFFBEEF);
    wait_resp("lh_s");
    do_req(1'b0, 2'b01, 1'b1, 32'h14, 32'd0, 1'b0, 32'h00007788);
    wait_resp("lh_u");

    // Highest legal word and the error cases
    preset(8'd255, 32'hCAFEF00D);
    do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'd0, 1'b0, 32'hCAFEF00D);
    wait_resp("lw_top");
    wc0 = wr_count;
    do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'd0, 1'b1, 32'd0);
    wait_resp("e_wmis");
    do_req(1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF, 1'b1, 32'd0);
    wait_resp("e_hmis");
    do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'd0, 1'b1, 32'd0);
    wait_resp("e_size");
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h5A5A5A5A, 1'b1, 32'd0);
    wait_resp("e_range");
    chk("err_no_write", 32'(wr_count - wc0), 32'd0);
    chk("err_mem0", mem[0], 32'd0);

    // Backpressure with a pending request
    resp_ready = 1'b0;
    wc0 = wr_count;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'h11AA3344);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_resp_valid", 32'(resp_valid), 32'd1);
    snap_rdata = resp_rdata;
    snap_err   = resp_err;
    req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'h99; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_rdata", resp_rdata, snap_rdata);
      chk("bp_hold_err", 32'(resp_err), 32'(snap_err));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    e = sb.pop_front();
    chk("bp_rdata", snap_rdata, e.rdata);
    chk("bp_err", 32'(snap_err), 32'(e.err));
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(resp_valid), 32'd0);
    chk("bp_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("bp_no_accept", 32'(wr_count - wc0), 32'd0);

    // Reset while a store sits in WRITE
    wc0 = wr_count;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_in_write", 32'(writeEn), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_writeEn_drop", 32'(writeEn), 32'd0);
    chk("mid_no_resp", 32'(resp_valid), 32'd0);
    chk("mid_A", A, 32'd0);
    @(negedge clk);
    chk("mid_no_write", 32'(wr_count - wc0), 32'd0);
    chk("mid_mem8", mem[8], 32'd0);
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'd0; req_valid = 1'b1;
    e.err = 1'b0; e.rdata = 32'd0;
    sb.push_back(e);
    @(negedge clk);
    chk("mid_ready_in_rst", 32'(req_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("first_edge_accept", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    wait_resp("post_rst_ld");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
